// File: rtl/conv2d_stream_pkg.sv
// conv2d_stream_pkg
//   Shared constants for the streaming 2-D convolution engine: default image
//   geometry, kernel side, word widths and the accumulator width needed to
//   sum K*K full-precision signed products without overflow.
package conv2d_stream_pkg;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int K_DEF     = 5;
  localparam int DW_DEF    = 32;
  localparam int OW_DEF    = 62;

  // Each product needs 2*dw bits; summing k*k of them adds ceil(log2(k*k)) bits.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

  localparam int ACC_W_DEF = acc_width(DW_DEF, K_DEF);

endpackage

// File: rtl/conv2d_stream_line_buffer.sv
// conv2d_stream_line_buffer
//   One image row of delay. Every enabled clock shifts a pixel in; the output
//   is the pixel accepted DEPTH enables earlier, i.e. the same column one row up.
//   Ports:
//     CLK   - rising-edge clock
//     en_i  - shift enable (pixel accepted)
//     d_i   - pixel in
//     q_o   - pixel from DEPTH accepted pixels ago
module conv2d_stream_line_buffer
  import conv2d_stream_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                 CLK,
  input  logic                 en_i,
  input  logic signed [DW-1:0] d_i,
  output logic signed [DW-1:0] q_o
);

  // Pure data storage: no reset, rows 0..K-2 of every frame refill it before
  // any window reads it.
  logic signed [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream
//   Streaming KxK valid-mode correlation over an IMG_W x IMG_H raster image.
//   Ports:
//     CLK, RST         - clock, asynchronous active-high reset
//     data_valid_in    - pixel strobe, data_in accepted on each high edge
//     data_in          - signed pixel, raster order
//     load_kernel      - kernel-load enable, words row-major on kernel
//     kernel           - signed kernel word
//     data_out         - low OW bits of the exact window sum
//     valid_out        - one-cycle pulse per result
//     load_kernel_done - all K*K kernel words held
module conv2d_stream
  import conv2d_stream_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = K_DEF,
  parameter int DW    = DW_DEF,
  parameter int OW    = OW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 data_valid_in,
  input  logic signed [DW-1:0] data_in,
  input  logic                 load_kernel,
  input  logic signed [DW-1:0] kernel,
  output logic [OW-1:0]        data_out,
  output logic                 valid_out,
  output logic                 load_kernel_done
);

  localparam int KK    = K * K;
  localparam int ACC_W = acc_width(DW, K);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int KCW   = $clog2(KK + 1);

  // Kernel load: kcount restarts whenever load_kernel drops, so each new
  // assertion rewrites from k[0][0]; the done flag survives the drop.
  logic signed [DW-1:0] k_q [KK];
  logic [KCW-1:0]       kcount_q;
  logic                 kdone_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < KK; i++) k_q[i] <= '0;
      kcount_q <= '0;
      kdone_q  <= 1'b0;
    end else if (load_kernel) begin
      if (kcount_q < KCW'(KK)) begin
        k_q[kcount_q] <= kernel;
        kcount_q      <= kcount_q + KCW'(1);
        kdone_q       <= (kcount_q == KCW'(KK - 1));
      end
    end else begin
      kcount_q <= '0;
    end
  end

  assign load_kernel_done = kdone_q;

  // Raster position of the pixel currently on data_in.
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_q <= '0;
      row_q <= '0;
    end else if (data_valid_in) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Line buffers are chained: buffer l outputs the pixel l+1 rows above.
  logic signed [DW-1:0] lb_in  [K-1];
  logic signed [DW-1:0] lb_out [K-1];

  for (genvar l = 0; l < K - 1; l++) begin : g_lb
    if (l == 0) begin : g_first
      assign lb_in[l] = data_in;
    end else begin : g_next
      assign lb_in[l] = lb_out[l-1];
    end
    conv2d_stream_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb (
      .CLK  (CLK),
      .en_i (data_valid_in),
      .d_i  (lb_in[l]),
      .q_o  (lb_out[l])
    );
  end

  // Window next state: shift one column left, new column enters at j=K-1
  // with the current pixel on the bottom row.
  logic signed [DW-1:0] col_vec [K];
  logic signed [DW-1:0] win_d   [K][K];
  logic signed [DW-1:0] win_q   [K][K];

  always_comb begin
    col_vec[K-1] = data_in;
    for (int l = 0; l < K - 1; l++) col_vec[K-2-l] = lb_out[l];
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
      win_d[i][K-1] = col_vec[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win_q[i][j] <= '0;
    end else if (data_valid_in) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win_q[i][j] <= win_d[i][j];
    end
  end

  // MAC over the completed window, using the kernel as it stands this edge.
  logic signed [2*DW-1:0] prod;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    prod  = '0;
    acc_d = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod  = (2*DW)'(k_q[i*K+j]) * (2*DW)'(win_d[i][j]);
        acc_d = acc_d + ACC_W'(prod);
      end
    end
  end

  logic win_full;
  assign win_full = data_valid_in && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

  // Output stage: result registered one edge after the completing pixel.
  logic [OW-1:0] data_q;
  logic          valid_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= win_full && kdone_q;
      if (win_full && kdone_q) data_q <= acc_d[OW-1:0];
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream
//   Randomised self-checking bench for conv2d_stream. A frame-level model
//   (image array, kernel array, exact wide sums) predicts every output cycle.
module tb_conv2d_stream;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               data_valid_in = 1'b0;
  logic signed [31:0] data_in = '0;
  logic               load_kernel = 1'b0;
  logic signed [31:0] kernel = '0;
  logic [61:0]        data_out;
  logic               valid_out;
  logic               load_kernel_done;

  conv2d_stream dut (
    .CLK              (CLK),
    .RST              (RST),
    .data_valid_in    (data_valid_in),
    .data_in          (data_in),
    .load_kernel      (load_kernel),
    .kernel           (kernel),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .load_kernel_done (load_kernel_done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  int          img [32][32];
  int          km  [25];
  int          kw  [25];
  int          kc_m;
  bit          done_m;
  logic [61:0] last_out;
  logic [61:0] res_q [$];
  logic [61:0] ref_q [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact correlation of the window ending at (r,c), truncated to 62 bits.
  function automatic logic [61:0] exp_at(input int r, input int c);
    logic signed [127:0] s, a, b;
    s = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        a = km[i*5+j];
        b = img[r-4+i][c-4+j];
        s = s + a * b;
      end
    end
    return s[61:0];
  endfunction

  task automatic step(input logic v, input logic [31:0] d);
    @(negedge CLK);
    data_valid_in = v;
    data_in       = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, $urandom);
      check_val("idle_vld", valid_out, 0);
      check_val("idle_hold", data_out, last_out);
    end
  endtask

  task automatic do_reset();
    data_valid_in = 1'b0;
    load_kernel   = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    for (int i = 0; i < 25; i++) km[i] = 0;
    kc_m = 0; done_m = 1'b0; last_out = '0;
    check_val("rst_data", data_out, 0);
    check_val("rst_vld", valid_out, 0);
    check_val("rst_kdone", load_kernel_done, 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Drive kw[0..24] followed by 'extra' ignored words, then drop load_kernel.
  task automatic load_words(input int extra);
    for (int n = 0; n < 25 + extra; n++) begin
      @(negedge CLK);
      data_valid_in = 1'b0;
      load_kernel   = 1'b1;
      kernel        = (n < 25) ? kw[n] : 32'h0BAD_F00D;
      @(posedge CLK);
      #1;
      if (kc_m < 25) begin
        km[kc_m] = (n < 25) ? kw[n] : 32'h0BAD_F00D;
        kc_m++;
        done_m = (kc_m == 25);
      end
      check_val("kdone", load_kernel_done, done_m);
      check_val("kload_vld", valid_out, 0);
    end
    @(negedge CLK);
    load_kernel = 1'b0;
    @(posedge CLK);
    #1;
    kc_m = 0;
    check_val("kdone_hold", load_kernel_done, done_m);
  endtask

  // Stream the first npix pixels of img with gap_pct% random idle cycles.
  task automatic run_frame(input int npix, input int gap_pct);
    int r, c;
    bit ev;
    logic [61:0] e;
    res_q.delete();
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / 32;
      c = idx % 32;
      while ($urandom_range(99) < gap_pct) begin
        step(1'b0, $urandom);
        check_val("gap_vld", valid_out, 0);
        check_val("gap_hold", data_out, last_out);
      end
      step(1'b1, img[r][c]);
      ev = done_m && (r >= 4) && (c >= 4);
      check_val("vld", valid_out, ev);
      if (ev) begin
        e = exp_at(r, c);
        check_val("data", data_out, e);
        last_out = e;
        res_q.push_back(data_out);
      end else begin
        check_val("hold", data_out, last_out);
      end
    end
    @(negedge CLK);
    data_valid_in = 1'b0;
  endtask

  task automatic fill_img_rand();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) img[r][c] = $urandom;
  endtask

  task automatic cmp_ref(input string tag);
    check_val({tag, "_len"}, res_q.size(), ref_q.size());
    if (res_q.size() == ref_q.size())
      for (int i = 0; i < res_q.size(); i++)
        if (res_q[i] !== ref_q[i]) check_val(tag, res_q[i], ref_q[i]);
  endtask

  logic [127:0] big;
  logic [61:0]  m50;

  initial begin
    #1;
    do_reset();

    // Kernel 1..25 plus one ignored word, then a random frame under it.
    for (int i = 0; i < 25; i++) kw[i] = i + 1;
    load_words(1);
    check_val("k44", km[24], 25);
    fill_img_rand();
    run_frame(1024, 0);
    check_val("seq_count", res_q.size(), 784);

    // Identity kernel, ramp image.
    for (int i = 0; i < 25; i++) kw[i] = 0;
    kw[24] = 1;
    load_words(0);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) img[r][c] = 32 * r + c;
    run_frame(1024, 0);
    check_val("id_count", res_q.size(), 784);
    if (res_q.size() == 784) begin
      check_val("id_first", res_q[0], 132);
      check_val("id_row_step", res_q[28], 164);
      check_val("id_last", res_q[783], 1023);
    end

    // All ones.
    for (int i = 0; i < 25; i++) kw[i] = 1;
    load_words(0);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) img[r][c] = 1;
    run_frame(1024, 0);
    check_val("ones_count", res_q.size(), 784);
    if (res_q.size() > 0) check_val("ones_first", res_q[0], 25);

    // Largest positive operands: wrap to 62 bits.
    for (int i = 0; i < 25; i++) kw[i] = 32'h7FFF_FFFF;
    load_words(0);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) img[r][c] = 32'h7FFF_FFFF;
    run_frame(1024, 0);
    big = 128'd25 * 128'h7FFF_FFFF * 128'h7FFF_FFFF;
    if (res_q.size() > 0) check_val("wrap_max", res_q[0], big[61:0]);

    // Negative kernel.
    for (int i = 0; i < 25; i++) kw[i] = -1;
    load_words(0);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) img[r][c] = 2;
    run_frame(1024, 0);
    m50 = -62'sd50;
    if (res_q.size() > 0) check_val("neg_first", res_q[0], m50);

    // Stalls: gapless reference vs. gapped run on the same random data.
    for (int i = 0; i < 25; i++) kw[i] = $urandom;
    load_words(0);
    fill_img_rand();
    run_frame(1024, 0);
    ref_q = res_q;
    run_frame(1024, 30);
    cmp_ref("stall_seq");
    idle(3);

    // Asynchronous reset mid-frame, a discarded frame without kernel,
    // then reload and two identical frames.
    run_frame(600, 20);
    do_reset();
    run_frame(1024, 10);
    check_val("nokern_count", res_q.size(), 0);
    load_words(0);
    fill_img_rand();
    run_frame(1024, 15);
    ref_q = res_q;
    check_val("post_rst_count", res_q.size(), 784);
    run_frame(1024, 15);
    cmp_ref("frame_repeat");
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
